// File: rtl/defines.sv
// Shared types and constants for the memory stage: writeback select, LSU FSM
// states, funct3 access-size encodings and a size-decode helper.
package defines;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; loads add the unsigned variants. Anything else is a word.
  function automatic acc_size_e access_size(input logic [2:0] funct3, input logic is_store);
    acc_size_e sz;
    sz = SZ_W;
    if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) sz = SZ_B;
    else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) sz = SZ_H;
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load lane selection and sign/zero extension of a read word.
module mem_load_ext
  import defines::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            byte_off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{byte_off, 3'b000} +: 8];
    half_sel = rdata[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: issues loads/stores on a req/gnt/rvalid data port,
// stalls the pipeline while an access is outstanding and registers MEM->WB.
module mem_stage_lsu
  import defines::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic                  MEM_RegWrite_i,
  input  wb_sel_e               MEM_WBSel_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  mem_stall_o,
  output logic                  WB_RegWrite_o,
  output wb_sel_e               WB_WBSel_o,
  output logic [4:0]            WB_rd_addr_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_load_data_o,
  output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
  output logic                  WB_misalign_o
);

  lsu_state_e state_reg, state_next;

  logic [2:0]            funct3;
  logic [1:0]            byte_off;
  logic                  is_access;
  logic                  is_store;
  acc_size_e             size;
  logic                  misalign;
  logic                  aligned_access;
  logic                  req_raw;
  logic                  stall_raw;
  logic [DATA_WIDTH-1:0] load_ext;

  assign funct3         = MEM_instruction_i[14:12];
  assign byte_off       = MEM_alu_result_i[1:0];
  assign is_access      = MEM_MemRead_i | MEM_MemWrite_i;
  // A request with both read and write set is a store.
  assign is_store       = MEM_MemWrite_i;
  assign size           = access_size(funct3, is_store);
  assign misalign       = is_access &
                          (((size == SZ_H) && byte_off[0]) ||
                           ((size == SZ_W) && (byte_off != 2'b00)));
  assign aligned_access = is_access & ~misalign;

  // Address/data come straight from MEM_* inputs, which upstream holds during a stall.
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    always_comb begin
      case (size)
        SZ_B: begin
          dmem_wdata_o[8*gi +: 8] = MEM_wr_data_i[7:0];
          dmem_be_o[gi]           = (byte_off == LANE);
        end
        SZ_H: begin
          dmem_wdata_o[8*gi +: 8] = MEM_wr_data_i[8*(gi%2) +: 8];
          dmem_be_o[gi]           = (byte_off[1] == LANE[1]);
        end
        default: begin
          dmem_wdata_o[8*gi +: 8] = MEM_wr_data_i[8*gi +: 8];
          dmem_be_o[gi]           = 1'b1;
        end
      endcase
    end
  end

  mem_load_ext u_load_ext (
    .rdata    (dmem_rdata_i),
    .byte_off (byte_off),
    .funct3   (funct3),
    .data     (load_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (aligned_access) begin
          if (!dmem_gnt_i)   state_next = REQ;
          else if (!is_store) state_next = WAIT_RSP;
        end
      end
      REQ: begin
        if (dmem_gnt_i) state_next = is_store ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_reg)
      IDLE: begin
        req_raw   = aligned_access;
        stall_raw = aligned_access & ~(is_store & dmem_gnt_i);
      end
      REQ: begin
        req_raw   = 1'b1;
        stall_raw = ~(is_store & dmem_gnt_i);
      end
      WAIT_RSP: begin
        stall_raw = ~dmem_rvalid_i;
      end
      default: ;
    endcase
  end

  assign dmem_req_o  = req_raw & ~rst;
  assign mem_stall_o = stall_raw & ~rst;

  // A stalled cycle sends a bubble; otherwise the instruction moves to WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_RegWrite_o   <= 1'b0;
      WB_WBSel_o      <= WB_NONE;
      WB_rd_addr_o    <= '0;
      WB_alu_result_o <= '0;
      WB_load_data_o  <= '0;
      WB_pc_plus4_o   <= '0;
      WB_misalign_o   <= 1'b0;
    end else if (stall_raw) begin
      WB_RegWrite_o   <= 1'b0;
      WB_WBSel_o      <= WB_NONE;
      WB_rd_addr_o    <= '0;
      WB_alu_result_o <= '0;
      WB_load_data_o  <= '0;
      WB_pc_plus4_o   <= '0;
      WB_misalign_o   <= 1'b0;
    end else begin
      WB_RegWrite_o   <= MEM_RegWrite_i & ~misalign;
      WB_WBSel_o      <= MEM_WBSel_i;
      WB_rd_addr_o    <= MEM_instruction_i[11:7];
      WB_alu_result_o <= MEM_alu_result_i;
      WB_load_data_o  <= (state_reg == WAIT_RSP) ? load_ext : '0;
      WB_pc_plus4_o   <= MEM_pc_plus4_i;
      WB_misalign_o   <= misalign;
    end
  end

endmodule
